// File: rtl/debug_scan_master.sv
// ============================================================================
// debug_scan_master: drives a 2-bit-IR virtual JTAG debug slave from one
// command word (uir, cdr, sdr, udr, rti) and returns the captured DR.
// Optional: DEBUG_SCAN_MASTER_LOOPBACK_EN adds loopback_en (capture from tdi).
// Revision: 1.0
// ============================================================================
`default_nettype none

module debug_scan_master #(
  parameter int IR_W    = 2,
  parameter int DR_W    = 38,
  parameter int LEN_W   = 6,
  parameter int TCK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IR_W-1:0]  cmd_ir,
  input  logic [DR_W-1:0]  cmd_dr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DR_W-1:0]  rsp_dr,
  output logic [LEN_W-1:0] rsp_len,
`ifdef DEBUG_SCAN_MASTER_LOOPBACK_EN
  input  logic             loopback_en,
`endif
  output logic             vji_tck,
  output logic             vji_tdi,
  input  logic             vji_tdo,
  output logic [IR_W-1:0]  vji_ir_in,
  output logic             vji_uir,
  output logic             vji_cdr,
  output logic             vji_sdr,
  output logic             vji_udr,
  output logic             vji_rti
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_UIR   = 3'd1;
  localparam logic [2:0] S_CDR   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_UDR   = 3'd4;
  localparam logic [2:0] S_RTI   = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  localparam logic [7:0]       DIV_LAST = 8'(TCK_DIV - 1);
  localparam logic [LEN_W-1:0] DR_W_L   = LEN_W'(DR_W);

  logic [2:0]       state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic             tck_q, tck_d;
  logic             tdi_q, tdi_d;
  logic [LEN_W-1:0] bit_q, bit_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic [DR_W-1:0]  sr_q, sr_d;

  logic             div_last;
  logic             cap_bit;
  logic [LEN_W-1:0] rsp_shamt;

`ifdef DEBUG_SCAN_MASTER_LOOPBACK_EN
  assign cap_bit = loopback_en ? tdi_q : vji_tdo;
`else
  assign cap_bit = vji_tdo;
`endif

  assign div_last  = (div_q == DIV_LAST);
  assign rsp_shamt = DR_W_L - len_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_last ? 8'd0 : div_q + 8'd1;
    tck_d   = tck_q;
    tdi_d   = tdi_q;
    bit_d   = bit_q;
    len_d   = len_q;
    ir_d    = ir_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: begin
        div_d = 8'd0;
        if (cmd_valid && cmd_ready) begin
          ir_d    = cmd_ir;
          sr_d    = cmd_dr;
          len_d   = (cmd_len > DR_W_L) ? DR_W_L : cmd_len;
          bit_d   = '0;
          state_d = S_UIR;
        end
      end
      S_UIR: if (div_last) state_d = (len_q != '0) ? S_CDR : S_RTI;
      S_CDR: begin
        if (div_last) begin
          state_d = S_SHIFT;
          tdi_d   = sr_q[0];
        end
      end
      S_SHIFT: begin
        // tdi is re-presented only at bit boundaries so it stays stable
        // across the whole bit even though sr shifts on the rising tck.
        if (div_last) begin
          if (!tck_q) begin
            tck_d = 1'b1;
            sr_d  = {cap_bit, sr_q[DR_W-1:1]};
            bit_d = bit_q + LEN_W'(1);
          end else begin
            tck_d = 1'b0;
            if (bit_q == len_q) begin
              state_d = S_UDR;
              tdi_d   = 1'b0;
            end else begin
              tdi_d = sr_q[0];
            end
          end
        end
      end
      S_UDR: if (div_last) state_d = S_RTI;
      S_RTI: if (div_last) state_d = S_RESP;
      S_RESP: begin
        div_d = 8'd0;
        if (rsp_ready) begin
          state_d = S_IDLE;
          ir_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      tck_q   <= 1'b0;
      tdi_q   <= 1'b0;
      bit_q   <= '0;
      len_q   <= '0;
      ir_q    <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tdi_q   <= tdi_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      sr_q    <= sr_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_dr    = rsp_valid ? (sr_q >> rsp_shamt) : '0;
  assign rsp_len   = rsp_valid ? len_q : '0;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = (state_q == S_UIR);
  assign vji_cdr   = (state_q == S_CDR);
  assign vji_sdr   = (state_q == S_SHIFT);
  assign vji_udr   = (state_q == S_UDR);
  assign vji_rti   = (state_q == S_RTI);

endmodule

`default_nettype wire

// File: doc/debug_scan_master.md
Name: debug_scan_master

Overview:
- Host-side initiator for the CPU debug slave's 2-bit-IR virtual JTAG scan interface.
- Takes one command word (IR value, DR payload, DR length) and generates the full scan sequence: ir_in/uir, cdr, sdr with divided tck and tdi shifting, then udr and run-test-idle.
- While shifting it captures tdo and returns the captured DR through a valid/ready response port.
- Used in system-level benches and in on-chip self-test logic that drives the debug slave without a physical JTAG cable.

Parameters:
- IR_W, 2, instruction register width driven on vji_ir_in.
- DR_W, 38, maximum data register length in bits; matches the debug slave shift register.
- LEN_W, 6, width of the length field; must satisfy 2**LEN_W > DR_W.
- TCK_DIV, 2, clk cycles per tck half-period; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle and accepting a command.
- cmd_ir  in  IR_W  instruction value.
- cmd_dr  in  DR_W  DR payload; bit 0 is shifted first.
- cmd_len  in  LEN_W  DR bits to shift; 0 = IR-only access.
- rsp_valid  out  1  capture result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_dr  out  DR_W  captured tdo bits; first captured bit in bit 0, unused upper bits 0.
- rsp_len  out  LEN_W  effective (clamped) length of the scan.
- vji_tck  out  1  divided scan clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_W  instruction presented to the slave.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual JTAG state strobes.

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after it; all other outputs 0; state=IDLE. A reset asserted mid-scan aborts the scan; no response is produced and all strobes are 0 from the next edge.
- States and dwell times (T = TCK_DIV clk cycles):
  - IDLE: cmd_ready=1. When cmd_valid&&cmd_ready, latch ir, dr and len_eff=min(cmd_len,DR_W), then go to UIR.
  - UIR: vji_uir=1 and vji_ir_in=latched ir for T cycles. Go to CDR if len_eff>0, else RTI.
  - CDR: vji_cdr=1 for T cycles, then SHIFT.
  - SHIFT: vji_sdr=1 throughout. Each bit takes 2T cycles: tck low for T, then high for T.
    - vji_tdi = sr[0], stable across the whole bit.
    - On the clk edge where tck rises, sample vji_tdo: sr <= {tdo, sr[DR_W-1:1]}, and the bit counter increments.
    - After len_eff rising edges, finish the high phase and go to UDR.
  - UDR: vji_udr=1 for T cycles, then RTI.
  - RTI: vji_rti=1 for T cycles, then RESP.
  - RESP: rsp_valid=1. Hold rsp_dr = sr >> (DR_W-len_eff) and rsp_len = len_eff until rsp_ready, then go to IDLE.
- Signal rules:
  - vji_ir_in holds the latched ir from UIR through RESP and resets to 0 on return to IDLE.
  - vji_tck=0 outside SHIFT.
  - At most one of uir/cdr/sdr/udr/rti is high in any cycle.
  - cmd_ready=0 in every state except IDLE. Commands offered while busy are not consumed.
- Response rules:
  - IR-only command (len_eff=0): rsp_dr=0, rsp_len=0.
  - If rsp_ready is already high when RESP is entered, the response lasts exactly one cycle. The next command cannot be accepted before the following cycle (IDLE).
- Latency: total cycles from acceptance to rsp_valid = T*(3 + 2*len_eff + 1) for len_eff>0, and 2T for len_eff=0.
- Length clamp: cmd_len > DR_W is clamped silently to DR_W.

Optional Feature:
- Macro: DEBUG_SCAN_MASTER_LOOPBACK_EN.
- When defined, an extra input loopback_en (1 bit) exists. While loopback_en=1, the capture path samples vji_tdi instead of vji_tdo, so rsp_dr equals cmd_dr masked to len_eff bits. All strobes are still generated.
- When not defined, the port is absent and capture always uses vji_tdo.

Test Plan:
- TCK_DIV=2, cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_A5A5, cmd_len=38, tdo tied to tdi externally -> rsp_dr=38'h2A_5A5A_A5A5, rsp_len=38, rsp_valid exactly 2*(3+76+1)=160 cycles after the accept edge; tck shows 38 rising edges.
- cmd_len=0, cmd_ir=2'b10 -> uir high 2 cycles with ir_in=2'b10, then rti 2 cycles; no cdr/sdr/udr pulses and no tck edges; rsp_dr=0, rsp_len=0.
- cmd_len=8, tdo driven with 8'b1100_0101 LSB first -> rsp_dr=38'h00_0000_00C5, rsp_len=8.
- cmd_len=50 -> clamped: 38 tck rising edges, rsp_len=38.
- Hold rsp_ready=0 for 20 cycles, with cmd_valid pulsed during SHIFT and during RESP -> rsp_valid and rsp_dr held stable, cmd_ready=0 throughout and no command consumed; cmd_ready=1 the cycle after the rsp handshake.
- Assert reset for 1 cycle mid-SHIFT at bit 5 -> next cycle all strobes and tck are 0 and rsp_valid=0; cmd_ready=1 one cycle later; a fresh 4-bit scan then completes correctly.
